// File: rtl/fault_detect_sched_if.sv
// Scheduler-side bundle: channel FIFO requests/data, pipeline start/data/verdict,
// result report and sticky fault map. master = scheduler, slave = surrounding logic.
interface fault_detect_sched_if #(
    parameter int N_CH = 4
);
    localparam int CW = $clog2(N_CH);

    logic [N_CH-1:0]       req_i;
    logic [N_CH-1:0][7:0]  data_i;
    logic [N_CH-1:0]       rd_o;
    logic                  pipe_start_o;
    logic [7:0]            pipe_data_o;
    logic                  pipe_fault_i;
    logic                  pipe_vaild_i;
    logic                  busy_o;
    logic                  result_valid_o;
    logic [CW-1:0]         result_ch_o;
    logic                  result_fault_o;
    logic                  result_timeout_o;
    logic                  clear_i;
    logic [N_CH-1:0]       fault_map_o;

    modport master (
        input  req_i, data_i, pipe_fault_i, pipe_vaild_i, clear_i,
        output rd_o, pipe_start_o, pipe_data_o, busy_o, result_valid_o,
               result_ch_o, result_fault_o, result_timeout_o, fault_map_o
    );

    modport slave (
        output req_i, data_i, pipe_fault_i, pipe_vaild_i, clear_i,
        input  rd_o, pipe_start_o, pipe_data_o, busy_o, result_valid_o,
               result_ch_o, result_fault_o, result_timeout_o, fault_map_o
    );
endinterface

// File: rtl/fault_detect_sched.sv
// Round-robin scheduler feeding one FFT/fault-detector pipeline from N_CH sample FIFOs.
// Define FAULT_SCHED_STICKY_MAP_EN to enable the sticky per-channel fault map.
module fault_detect_sched #(
    parameter int N_CH      = 4,
    parameter int FRAME_LEN = 256,
    parameter int TIMEOUT   = 4096
) (
    input  logic                clk_i,
    input  logic                rst_i,
    fault_detect_sched_if.master bus
);
    localparam int CW = $clog2(N_CH);
    localparam int FW = $clog2(FRAME_LEN);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, STREAM, WAIT, REPORT} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] gnt, last, pick;
    logic          pick_vld;
    logic [FW-1:0] cnt;
    logic [TW-1:0] tcnt;
    logic          frame_done, tmo_hit;
    logic          start_q, fault_q, timeout_q;
    logic [7:0]    data_q;

    // first requester strictly after the previous grant, wrapping
    always_comb begin
        pick     = last;
        pick_vld = 1'b0;
        for (int i = 1; i <= N_CH; i++) begin
            if (!pick_vld && bus.req_i[CW'((int'(last) + i) % N_CH)]) begin
                pick     = CW'((int'(last) + i) % N_CH);
                pick_vld = 1'b1;
            end
        end
    end

    assign frame_done = (cnt == FW'(FRAME_LEN - 1));
    assign tmo_hit    = (tcnt == TW'(TIMEOUT - 1));

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pick_vld) state_nxt = STREAM;
            STREAM:  if (frame_done) state_nxt = WAIT;
            WAIT:    if (bus.pipe_vaild_i || tmo_hit) state_nxt = REPORT;
            REPORT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            gnt       <= '0;
            last      <= CW'(N_CH - 1);
            cnt       <= '0;
            tcnt      <= '0;
            start_q   <= 1'b0;
            fault_q   <= 1'b0;
            timeout_q <= 1'b0;
            data_q    <= '0;
        end else begin
            // start rides with sample 0, which is captured on the cnt==0 cycle
            start_q <= (state == STREAM) && (cnt == '0);
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        gnt  <= pick;
                        last <= pick;
                        cnt  <= '0;
                    end
                end
                STREAM: begin
                    data_q <= bus.data_i[gnt];
                    cnt    <= cnt + 1'b1;
                    tcnt   <= '0;
                end
                WAIT: begin
                    tcnt <= tcnt + 1'b1;
                    // a verdict arriving on the timeout cycle takes precedence
                    if (bus.pipe_vaild_i) begin
                        fault_q   <= bus.pipe_fault_i;
                        timeout_q <= 1'b0;
                    end else if (tmo_hit) begin
                        fault_q   <= 1'b0;
                        timeout_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.rd_o             = (state == STREAM) ? (N_CH'(1) << gnt) : '0;
    assign bus.pipe_start_o     = start_q;
    assign bus.pipe_data_o      = data_q;
    assign bus.busy_o           = (state != IDLE);
    assign bus.result_valid_o   = (state == REPORT);
    assign bus.result_ch_o      = gnt;
    assign bus.result_fault_o   = fault_q;
    assign bus.result_timeout_o = timeout_q;

`ifdef FAULT_SCHED_STICKY_MAP_EN
    logic [N_CH-1:0] map_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            map_q <= '0;
        end else begin
            if (bus.clear_i) map_q <= '0;
            if (state == REPORT && fault_q) map_q[gnt] <= 1'b1;
        end
    end

    assign bus.fault_map_o = map_q;
`else
    logic unused_clear;
    assign unused_clear    = bus.clear_i;
    assign bus.fault_map_o = '0;
`endif
endmodule

// File: tb/tb_fault_detect_sched.sv
// Directed bench for fault_detect_sched: FIFO model per channel, hand-computed timing.
module tb_fault_detect_sched;
    localparam int N_CH = 4, FRAME_LEN = 8, TIMEOUT = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0, failures = 0;
    logic       ptr_clr = 1'b1;
    logic [5:0] ptr [N_CH];

    fault_detect_sched_if #(.N_CH(N_CH)) bus ();

    fault_detect_sched #(.N_CH(N_CH), .FRAME_LEN(FRAME_LEN), .TIMEOUT(TIMEOUT)) dut (
        .clk_i(clk), .rst_i(rst), .bus(bus.master)
    );

    always #5 clk = ~clk;

    // show-ahead FIFO model: channel c head = {c, pop count}
    always @(posedge clk) begin
        for (int c = 0; c < N_CH; c++) begin
            if (ptr_clr)           ptr[c] <= '0;
            else if (bus.rd_o[c])  ptr[c] <= ptr[c] + 6'd1;
        end
    end

    always_comb begin
        bus.data_i = '0;
        for (int c = 0; c < N_CH; c++) bus.data_i[c] = {2'(c), ptr[c]};
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b0; ptr_clr = 1'b1;
        bus.req_i = '0; bus.pipe_vaild_i = 1'b0; bus.pipe_fault_i = 1'b0; bus.clear_i = 1'b0;
        tick; tick;
        rst = 1'b1;
        tick;
        ptr_clr = 1'b0;
    endtask

    task automatic test_reset;
        bus.req_i = '0; bus.pipe_vaild_i = 1'b0; bus.pipe_fault_i = 1'b0; bus.clear_i = 1'b0;
        tick; tick;
        checks++; if (bus.busy_o !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy_o); end
        checks++; if (bus.rd_o !== 4'b0) begin failures++; $display("FAIL reset_rd got=%b exp=0000", bus.rd_o); end
        checks++; if (bus.pipe_start_o !== 1'b0 || bus.pipe_data_o !== 8'h00) begin
            failures++; $display("FAIL reset_pipe start=%b data=%h exp=0/00", bus.pipe_start_o, bus.pipe_data_o); end
        checks++; if (bus.result_valid_o !== 1'b0 || bus.result_fault_o !== 1'b0 || bus.result_timeout_o !== 1'b0 || bus.result_ch_o !== 2'd0) begin
            failures++; $display("FAIL reset_result v=%b f=%b t=%b ch=%0d exp=0", bus.result_valid_o,
                                 bus.result_fault_o, bus.result_timeout_o, bus.result_ch_o); end
        checks++; if (bus.fault_map_o !== 4'b0) begin failures++; $display("FAIL reset_map got=%b exp=0000", bus.fault_map_o); end
        rst = 1'b1;
        tick;
        ptr_clr = 1'b0;
    endtask

    // ch2 alone, verdict fault=1 twenty cycles after the start pulse
    task automatic test_single;
        logic [3:0] exp_rd;
        logic [7:0] exp_d;
        do_reset;
        bus.req_i = 4'b0100;
        for (int k = 1; k <= 30; k++) begin
            tick;
            exp_rd = (k >= 1 && k <= 8) ? 4'b0100 : 4'b0000;
            checks++; if (bus.rd_o !== exp_rd) begin failures++; $display("FAIL single_rd k=%0d got=%b exp=%b", k, bus.rd_o, exp_rd); end
            checks++; if (bus.pipe_start_o !== (k == 2)) begin failures++; $display("FAIL single_start k=%0d got=%b exp=%b", k, bus.pipe_start_o, (k == 2)); end
            if (k >= 2) begin
                exp_d = 8'h80 + 8'(((k < 9) ? k : 9) - 2);
                checks++; if (bus.pipe_data_o !== exp_d) begin failures++; $display("FAIL single_data k=%0d got=%h exp=%h", k, bus.pipe_data_o, exp_d); end
            end
            checks++; if (bus.busy_o !== (k <= 23)) begin failures++; $display("FAIL single_busy k=%0d got=%b exp=%b", k, bus.busy_o, (k <= 23)); end
            checks++; if (bus.result_valid_o !== (k == 23)) begin failures++; $display("FAIL single_valid k=%0d got=%b exp=%b", k, bus.result_valid_o, (k == 23)); end
            if (k == 23) begin
                checks++; if (bus.result_ch_o !== 2'd2 || bus.result_fault_o !== 1'b1 || bus.result_timeout_o !== 1'b0) begin
                    failures++; $display("FAIL single_result ch=%0d f=%b t=%b exp=2/1/0", bus.result_ch_o, bus.result_fault_o, bus.result_timeout_o); end
            end
            if (k == 1) bus.req_i = 4'b0000;
            if (k == 22) begin bus.pipe_vaild_i = 1'b1; bus.pipe_fault_i = 1'b1; end
            if (k == 23) begin bus.pipe_vaild_i = 1'b0; bus.pipe_fault_i = 1'b0; end
        end
    endtask

    // all channels requesting, verdict always ready: 0,1,2,3,0,1,2,3 with one IDLE gap
    task automatic test_back_to_back;
        int n;
        do_reset;
        bus.pipe_vaild_i = 1'b1; bus.pipe_fault_i = 1'b0;
        bus.req_i = 4'b1111;
        tick;
        checks++; if (bus.rd_o !== 4'b0001) begin failures++; $display("FAIL rr_first got=%b exp=0001", bus.rd_o); end
        for (int f = 0; f < 8; f++) begin
            n = 0;
            while (bus.result_valid_o !== 1'b1 && n < 60) begin tick; n++; end
            checks++; if (bus.result_valid_o !== 1'b1) begin failures++; $display("FAIL rr_wait frame=%0d got=%b exp=1", f, bus.result_valid_o); end
            checks++; if (bus.result_ch_o !== 2'(f % 4)) begin failures++; $display("FAIL rr_order frame=%0d got=%0d exp=%0d", f, bus.result_ch_o, f % 4); end
            tick;
            checks++; if (bus.busy_o !== 1'b0) begin failures++; $display("FAIL rr_idle frame=%0d busy=%b exp=0", f, bus.busy_o); end
            if (f == 7) bus.req_i = 4'b0000;
            tick;
            if (f < 7) begin
                checks++; if (bus.rd_o !== (4'b0001 << ((f + 1) % 4))) begin
                    failures++; $display("FAIL rr_gap frame=%0d rd=%b exp=%b", f, bus.rd_o, 4'b0001 << ((f + 1) % 4)); end
            end
        end
        bus.pipe_vaild_i = 1'b0;
    endtask

    task automatic test_timeout;
        do_reset;
        bus.req_i = 4'b0001;
        for (int k = 1; k <= 30; k++) begin
            tick;
            if (k == 1) bus.req_i = 4'b0000;
            checks++; if (bus.result_valid_o !== (k == 25)) begin failures++; $display("FAIL tmo_valid k=%0d got=%b exp=%b", k, bus.result_valid_o, (k == 25)); end
            if (k == 25) begin
                checks++; if (bus.result_ch_o !== 2'd0 || bus.result_fault_o !== 1'b0 || bus.result_timeout_o !== 1'b1) begin
                    failures++; $display("FAIL tmo_result ch=%0d f=%b t=%b exp=0/0/1", bus.result_ch_o, bus.result_fault_o, bus.result_timeout_o); end
            end
        end
    endtask

    // stray strobe in STREAM, then verdict exactly on the timeout cycle
    task automatic test_collision;
        logic [3:0] exp_rd;
        logic [3:0] exp_map;
`ifdef FAULT_SCHED_STICKY_MAP_EN
        exp_map = 4'b0010;
`else
        exp_map = 4'b0000;
`endif
        do_reset;
        bus.req_i = 4'b0010;
        for (int k = 1; k <= 27; k++) begin
            tick;
            if (k == 1) bus.req_i = 4'b0000;
            exp_rd = (k <= 8) ? 4'b0010 : 4'b0000;
            checks++; if (bus.rd_o !== exp_rd) begin failures++; $display("FAIL col_rd k=%0d got=%b exp=%b", k, bus.rd_o, exp_rd); end
            checks++; if (bus.result_valid_o !== (k == 25)) begin failures++; $display("FAIL col_valid k=%0d got=%b exp=%b", k, bus.result_valid_o, (k == 25)); end
            if (k == 25) begin
                checks++; if (bus.result_ch_o !== 2'd1 || bus.result_fault_o !== 1'b1 || bus.result_timeout_o !== 1'b0) begin
                    failures++; $display("FAIL col_result ch=%0d f=%b t=%b exp=1/1/0", bus.result_ch_o, bus.result_fault_o, bus.result_timeout_o); end
            end
            if (k == 26) begin
                checks++; if (bus.fault_map_o !== exp_map) begin failures++; $display("FAIL col_map got=%b exp=%b", bus.fault_map_o, exp_map); end
            end
            if (k == 3 || k == 24) begin bus.pipe_vaild_i = 1'b1; bus.pipe_fault_i = 1'b1; end
            if (k == 4 || k == 25) begin bus.pipe_vaild_i = 1'b0; bus.pipe_fault_i = 1'b0; end
        end
    endtask

    task automatic test_reset_mid;
        do_reset;
        bus.req_i = 4'b0100;
        for (int k = 1; k <= 5; k++) tick;
        checks++; if (bus.pipe_data_o !== 8'h83) begin failures++; $display("FAIL mid_sample3 got=%h exp=83", bus.pipe_data_o); end
        rst = 1'b0;
        #1;
        checks++; if (bus.busy_o !== 1'b0 || bus.rd_o !== 4'b0 || bus.pipe_start_o !== 1'b0 || bus.pipe_data_o !== 8'h00) begin
            failures++; $display("FAIL mid_outputs busy=%b rd=%b start=%b data=%h exp=0", bus.busy_o, bus.rd_o, bus.pipe_start_o, bus.pipe_data_o); end
        checks++; if (bus.result_valid_o !== 1'b0 || bus.fault_map_o !== 4'b0) begin
            failures++; $display("FAIL mid_result v=%b map=%b exp=0", bus.result_valid_o, bus.fault_map_o); end
        bus.req_i = 4'b0101;
        tick; tick;
        rst = 1'b1;
        tick;
        checks++; if (bus.rd_o !== 4'b0001) begin failures++; $display("FAIL mid_regrant got=%b exp=0001", bus.rd_o); end
        bus.req_i = 4'b0000;
    endtask

`ifdef FAULT_SCHED_STICKY_MAP_EN
    task automatic test_sticky;
        logic [3:0] seq_req [4];
        logic [3:0] seq_map [4];
        int n;
        seq_req[0] = 4'b0010; seq_map[0] = 4'b0010;
        seq_req[1] = 4'b1000; seq_map[1] = 4'b1010;
        seq_req[2] = 4'b1000; seq_map[2] = 4'b1000;
        seq_req[3] = 4'b0010; seq_map[3] = 4'b0010;
        do_reset;
        bus.pipe_vaild_i = 1'b1; bus.pipe_fault_i = 1'b1;
        for (int s = 0; s < 4; s++) begin
            bus.req_i = seq_req[s];
            tick;
            bus.req_i = 4'b0000;
            n = 0;
            while (bus.result_valid_o !== 1'b1 && n < 60) begin tick; n++; end
            checks++; if (bus.result_valid_o !== 1'b1) begin failures++; $display("FAIL map_wait step=%0d got=%b exp=1", s, bus.result_valid_o); end
            if (s == 3) bus.clear_i = 1'b1;
            tick;
            bus.clear_i = 1'b0;
            checks++; if (bus.fault_map_o !== seq_map[s]) begin failures++; $display("FAIL map_step step=%0d got=%b exp=%b", s, bus.fault_map_o, seq_map[s]); end
            if (s == 1) begin
                bus.clear_i = 1'b1;
                tick;
                bus.clear_i = 1'b0;
                checks++; if (bus.fault_map_o !== 4'b0) begin failures++; $display("FAIL map_clear got=%b exp=0000", bus.fault_map_o); end
            end
        end
        bus.pipe_vaild_i = 1'b0; bus.pipe_fault_i = 1'b0;
    endtask
`endif

    initial begin
        test_reset;
        test_single;
        test_back_to_back;
        test_timeout;
        test_collision;
        test_reset_mid;
`ifdef FAULT_SCHED_STICKY_MAP_EN
        test_sticky;
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
